// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate cell checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } chk_state_e;

  // Expected cell output, indexed by {a,b}
  localparam logic [3:0] EXP_NOR  = 4'b0001;
  localparam logic [3:0] EXP_NAND = 4'b0111;

  localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; zero flags the end of the settle window.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  // Load has priority; otherwise count down and rest at zero
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nor_cell_checker.sv
// Stimulus driver / response monitor for a two-input gate cell.
// Walks {a,b} through 00,01,10,11, samples dut_out after SETTLE_CYCLES
// and records per-vector mismatches.
// Optional macro CHECK_NAND_EN: check against the NAND truth table
// instead of NOR; nothing else changes.
module nor_cell_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2  // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

`ifdef CHECK_NAND_EN
  localparam logic [3:0] EXP_TBL = EXP_NAND;
`else
  localparam logic [3:0] EXP_TBL = EXP_NOR;
`endif

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

  chk_state_e state, nxt;
  logic [1:0] vec;       // current vector index, doubles as {a,b}
  logic       load;
  logic       zero;
  logic       mismatch;
  logic [3:0] fail_nxt;

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (LOAD_VAL),
    .zero     (zero)
  );

  // Case inequality so that X or Z on the cell output counts as a failure
  assign mismatch = (dut_out !== EXP_TBL[vec]);

  // Failure vector including the vector being sampled this cycle
  always_comb begin
    fail_nxt = fail_vec;
    if (mismatch) fail_nxt[vec] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state; timer is reloaded on every entry to SETTLE
  always_comb begin
    nxt  = state;
    load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt  = SETTLE;
          load = 1'b1;
        end
      end
      SETTLE: begin
        if (zero) nxt = SAMPLE;
      end
      SAMPLE: begin
        if (vec == LAST_VEC) begin
          nxt = DONE;
        end else begin
          nxt  = SETTLE;
          load = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Vector index and result registers; pass settles on the last sample
  // edge so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      fail_vec  <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            fail_vec  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        SAMPLE: begin
          fail_vec <= fail_nxt;
          if (mismatch) err_count <= err_count + 3'd1;
          if (vec == LAST_VEC) pass <= (fail_nxt == '0);
          else                 vec  <= vec + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign dut_a = vec[1];
  assign dut_b = vec[0];
  assign busy  = (state == SETTLE) || (state == SAMPLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_nor_cell_checker.sv
// Directed bench for nor_cell_checker with a behavioural gate model that
// can be switched between good and faulty cells.
module tb_nor_cell_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  wire        dut_out;
  logic       dut_a, dut_b, busy, done, pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  int   mode;   // 0 NOR,1 stuck0,2 NAND,3 stuck1,4 OR,5 Z at 10,6 Z at 00
  logic mdl, flt;
  wire  zprobe;
  logic z_reads_low;

  int errors = 0;
  int checks = 0;

  nor_cell_checker #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_out   (dut_out),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    mdl = ~(dut_a | dut_b);
    flt = 1'b0;
    case (mode)
      1: mdl = 1'b0;
      2: mdl = ~(dut_a & dut_b);
      3: mdl = 1'b1;
      4: mdl = dut_a | dut_b;
      5: flt = dut_a & ~dut_b;
      6: flt = ~dut_a & ~dut_b;
      default: ;
    endcase
  end

  assign dut_out = flt ? 1'bz : mdl;
  assign zprobe  = 1'bz;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    logic [3:0] fail;
    logic [2:0] err;
    logic       pass;
    string      nm;
  } vec_t;

  vec_t tbl[7];

  // One full run from an idle checker; default timing (12 busy, done at 13)
  task automatic run(input vec_t v);
    int nbusy, ndone, dcyc;
    logic [3:0] ef;
    logic [2:0] ee;
    logic       ep;
    ef = v.fail; ee = v.err; ep = v.pass;
`ifndef CHECK_NAND_EN
    // A two-state simulator reads the floating net as 0, which equals the
    // NOR output for vector 10, so no mismatch is visible there.
    if (v.mode == 5 && z_reads_low) begin
      ef = 4'b0000; ee = 3'd0; ep = 1'b1;
    end
`endif
    mode  = v.mode;
    nbusy = 0; ndone = 0; dcyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (busy) nbusy++;
      if (c == 1) chk({v.nm, " cleared"}, {fail_vec, err_count, pass}, 8'h00);
      if (c % 3 == 0 && c <= 12)
        chk({v.nm, " vector"}, {6'd0, dut_a, dut_b}, 8'(c / 3 - 1));
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = c;
        chk({v.nm, " fail_vec"}, {4'd0, fail_vec}, {4'd0, ef});
        chk({v.nm, " err_count"}, {5'd0, err_count}, {5'd0, ee});
        chk({v.nm, " pass"}, {7'd0, pass}, {7'd0, ep});
      end
      @(negedge clk);
    end
    chk({v.nm, " busy cycles"}, 8'(nbusy), 8'd12);
    chk({v.nm, " done cycle"}, 8'(dcyc), 8'd13);
    chk({v.nm, " done count"}, 8'(ndone), 8'd1);
    chk({v.nm, " held"}, {fail_vec, err_count, pass}, {ef, ee, ep});
  endtask

  initial begin
    int ndone, dcyc;
`ifdef CHECK_NAND_EN
    tbl[0] = '{0, 4'b0110, 3'd2, 1'b0, "nor_cell"};
    tbl[1] = '{1, 4'b0111, 3'd3, 1'b0, "stuck0"};
    tbl[2] = '{2, 4'b0000, 3'd0, 1'b1, "nand_cell"};
    tbl[3] = '{3, 4'b1000, 3'd1, 1'b0, "stuck1"};
    tbl[4] = '{4, 4'b1001, 3'd2, 1'b0, "or_cell"};
    tbl[5] = '{5, 4'b0110, 3'd2, 1'b0, "float_10"};
    tbl[6] = '{6, 4'b0111, 3'd3, 1'b0, "float_00"};
`else
    tbl[0] = '{0, 4'b0000, 3'd0, 1'b1, "nor_cell"};
    tbl[1] = '{1, 4'b0001, 3'd1, 1'b0, "stuck0"};
    tbl[2] = '{2, 4'b0110, 3'd2, 1'b0, "nand_cell"};
    tbl[3] = '{3, 4'b1110, 3'd3, 1'b0, "stuck1"};
    tbl[4] = '{4, 4'b1111, 3'd4, 1'b0, "or_cell"};
    tbl[5] = '{5, 4'b0100, 3'd1, 1'b0, "float_10"};
    tbl[6] = '{6, 4'b0001, 3'd1, 1'b0, "float_00"};
`endif
    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    #1 z_reads_low = (zprobe === 1'b0);

    repeat (3) @(negedge clk);
    chk("reset outputs", {dut_a, dut_b, busy, done, pass, 3'd0},  8'h00);
    chk("reset results", {1'b0, fail_vec, err_count}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run(tbl[i]);

    // start during a run is ignored; restart right after done clears results
    mode = 1; ndone = 0; dcyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (done) begin ndone++; if (dcyc == 0) dcyc = c; end
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (c == 14) begin
        chk("restart idle", {6'd0, busy, done}, 8'h00);
        chk("restart old results", {1'b0, fail_vec, err_count}, {1'b0, 4'b0001, 3'd1});
        start = 1'b1;
      end
      if (c == 15) begin
        start = 1'b0;
        chk("restart busy", {7'd0, busy}, 8'd1);
        chk("restart cleared", {fail_vec, err_count, pass}, 8'h00);
      end
      @(negedge clk);
    end
    chk("busy start done count", 8'(ndone), 8'd1);
    chk("busy start done cycle", 8'(dcyc), 8'd13);
    repeat (14) @(negedge clk);

    // reset in cycle 5 aborts the run
    mode = 1; ndone = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        chk("pre-reset state", {dut_a, dut_b, busy, fail_vec, 1'b0},
            {1'b0, 1'b1, 1'b1, 4'b0001, 1'b0});
        rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    chk("abort outputs", {dut_a, dut_b, busy, done, pass, 3'd0}, 8'h00);
    chk("abort results", {1'b0, fail_vec, err_count}, 8'h00);
    for (int c = 0; c < 20; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort no done", 8'(ndone), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nor_cell_checker.md
# nor_cell_checker

Self-checking stimulus driver and response monitor for a two-input switch-level gate cell. On `start` it drives the cell's `a`/`b` inputs through all four input combinations and samples the cell output after a programmable settle time. It compares each sample against the expected truth table and reports per-vector failures, a mismatch count and an overall pass flag. It sits in the assignment test harness as the active counterpart to the gate under test: it drives the cell inputs and reads the cell output.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1–15.

Ports:
- `clk`  input  1: single clock; all logic on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: one-cycle request to begin a check run. Honoured only in IDLE.
- `dut_out`  input  1: gate cell output, sampled in SAMPLE.
- `dut_a`  output  1: cell input a.
- `dut_b`  output  1: cell input b.
- `busy`  output  1: high during SETTLE and SAMPLE.
- `done`  output  1: one-cycle pulse when results become valid.
- `pass`  output  1: high when `fail_vec == 0`. Valid from `done` until the next accepted `start`.
- `fail_vec`  output  4: bit i is set if vector i mismatched, where i = {a,b}.
- `err_count`  output  3: number of mismatching vectors, 0–4.

## Operation
- Reset values:
  - `dut_a`=0, `dut_b`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `fail_vec`=0, `err_count`=0.
  - state=IDLE, vector index=0.
- Vector order: index 0..3, driven as {`dut_a`,`dut_b`} = 00, 01, 10, 11.
- States:
  - **IDLE**: on `start`=1, clear `fail_vec`, `err_count` and `pass`; drive vector 0; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - **SETTLE**: hold the vector. When the counter reaches 0 go to SAMPLE; otherwise decrement.
  - **SAMPLE**: compare `dut_out` with expected[index] using case equality.
    - On mismatch, set `fail_vec[index]` and increment `err_count`.
    - An X or Z on `dut_out` is a mismatch.
    - If index<3: increment index, drive the next vector, reload the counter, go to SETTLE.
    - If index=3: go to DONE.
  - **DONE**: `done`=1 and `busy`=0 for one cycle; `pass` is updated; go to IDLE.
- Output holding:
  - `dut_a`/`dut_b` keep the last vector (11) after a run until the next start or reset.
  - Results hold until the next accepted `start`.
- `start` asserted in SETTLE, SAMPLE or DONE is ignored; it is not queued.
- `rst` asserted mid-run aborts immediately on that edge. All outputs return to reset values and no `done` is produced.
- The expected table is a 4-bit constant indexed by {a,b}: 4'b0001 for NOR.

## Timing
- Per vector: SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- `start` sampled at edge E0 → `busy` high from E0+1 for 4×(SETTLE_CYCLES+1) cycles.
- `done` pulses in the following cycle: with the default parameter, `busy` spans cycles 1–12 and `done` is high in cycle 13.
- `dut_a`/`dut_b` change only on entry to SETTLE. Each vector is therefore stable for at least SETTLE_CYCLES+1 edges before and including its sample edge.
- `err_count` and `fail_vec` update on the sample edge. They are final when `done` is high.
- The earliest back-to-back run accepts `start` in the cycle after `done`.

## Configuration
- `CHECK_NAND_EN`
  - Defined: the expected table is 4'b0111 (NAND: output 0 only for a=b=1), so the same block verifies the dual cell.
  - Undefined: the expected table is 4'b0001 (NOR: output 1 only for a=b=0).
  - Nothing else changes: ports, timing and state machine are identical.

## Structure
- Shared package `gate_chk_pkg`:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - `EXP_NOR`=4'b0001 and `EXP_NAND`=4'b0111;
  - `NUM_VECTORS`=4.
- One sub-module, `settle_timer`: loadable down-counter with a `load` input, a 4-bit load value and a `zero` flag. Instantiated once.
- FSM, vector index, compare logic and result registers live in `nor_cell_checker`.

## Test plan
- **Good NOR cell**: connect the NOR cell, SETTLE_CYCLES=2, pulse `start` → `busy` for 12 cycles, `done` in cycle 13, `pass`=1, `fail_vec`=0000, `err_count`=0.
- **Stuck-at-0 output**: tie `dut_out`=0 → `fail_vec`=0001, `err_count`=1, `pass`=0.
- **Wrong cell with default build**: connect a NAND cell → `fail_vec`=0110, `err_count`=2. Rebuild with `CHECK_NAND_EN` → `pass`=1.
- **Floating output**: drive `dut_out`=Z for vector 10 only → `fail_vec`=0100, `err_count`=1.
- **Reset mid-run**: pulse `start`, then `rst` in cycle 5 → next cycle `busy`=0, `dut_a`=`dut_b`=0, `fail_vec`=0, and no `done` afterwards.
- **Start while busy**: pulse `start` again in cycle 4 → the run still ends with a single `done` in cycle 13. A new `start` in cycle 14 begins a fresh run, with results cleared in cycle 15.
